// File: rtl/line_pkg.sv
// Shared types and helpers for the line command sequencer.
package line_pkg;

  localparam int COORD_W = 11;
  localparam int LEN_W   = 12;

  typedef struct packed {
    logic [COORD_W-1:0] x0, y0, x1, y1;
  } line_ends_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW} seq_state_e;

  function automatic logic [LEN_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    logic [COORD_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return {1'b0, d};
  endfunction

  // Pixel count of a line: the longer axis span plus one (1..2048).
  function automatic logic [LEN_W-1:0] line_len(input line_ends_t e);
    logic [LEN_W-1:0] dx, dy;
    dx = abs_diff(e.x1, e.x0);
    dy = abs_diff(e.y1, e.y0);
    return ((dx >= dy) ? dx : dy) + LEN_W'(1);
  endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous show-ahead FIFO holding queued line commands.
module line_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 45
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit tells full from empty when the addresses coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/line_sequencer.sv
// Buffers line commands, sequences them into line_drawer and forwards
// its pixels as colour-tagged framebuffer writes.
module line_sequencer
  import line_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COLOR_W    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               ld_reset,
  output logic [COORD_W-1:0] ld_x0,
  output logic [COORD_W-1:0] ld_y0,
  output logic [COORD_W-1:0] ld_x1,
  output logic [COORD_W-1:0] ld_y1,
  input  logic [COORD_W-1:0] ld_x,
  input  logic [COORD_W-1:0] ld_y,
  output logic               px_we,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic [COLOR_W-1:0] px_color,
  output logic               busy,
  output logic [15:0]        lines_done
);

  localparam int CMD_W = $bits(line_ends_t) + COLOR_W;

  seq_state_e         state;
  line_ends_t         cur_ends;
  logic [COLOR_W-1:0] cur_color;
  logic [LEN_W-1:0]   remaining;

  logic [CMD_W-1:0]   fifo_din;
  logic [CMD_W-1:0]   fifo_dout;
  line_ends_t         next_ends;
  logic [COLOR_W-1:0] next_color;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               last_px;

  assign fifo_din                = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
  assign {next_ends, next_color} = fifo_dout;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  assign last_px   = (state == DRAW) && (remaining == LEN_W'(1));
  // A new command is taken either from idle or straight after the last pixel.
  assign pop       = !fifo_empty && ((state == IDLE) || last_px);

  line_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ld_x0 = cur_ends.x0;
  assign ld_y0 = cur_ends.y0;
  assign ld_x1 = cur_ends.x1;
  assign ld_y1 = cur_ends.y1;

  assign busy = !fifo_empty || (state != IDLE) || px_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_ends   <= '0;
      cur_color  <= '0;
      remaining  <= '0;
      ld_reset   <= 1'b0;
      px_we      <= 1'b0;
      px_x       <= '0;
      px_y       <= '0;
      px_color   <= '0;
      lines_done <= '0;
    end else begin
      ld_reset <= 1'b0;
      px_we    <= 1'b0;
      if (pop) begin
        cur_ends  <= next_ends;
        cur_color <= next_color;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            ld_reset <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          remaining <= line_len(cur_ends);
          state     <= DRAW;
        end
        DRAW: begin
          // Pixel stage boundary: line_drawer output registered with colour.
          px_we     <= 1'b1;
          px_x      <= ld_x;
          px_y      <= ld_y;
          px_color  <= cur_color;
          remaining <= remaining - LEN_W'(1);
          if (last_px) begin
            lines_done <= lines_done + 16'd1;
            if (pop) begin
              ld_reset <= 1'b1;
              state    <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_sequencer.sv
// Directed bench for line_sequencer with a Bresenham stand-in for line_drawer.
module tb_line_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [10:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [0:0]  cmd_color = '0;
  logic        ld_reset;
  logic [10:0] ld_x0, ld_y0, ld_x1, ld_y1;
  logic [10:0] ld_x, ld_y;
  logic        px_we;
  logic [10:0] px_x, px_y;
  logic [0:0]  px_color;
  logic        busy;
  logic [15:0] lines_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  line_sequencer #(.FIFO_DEPTH(4), .COLOR_W(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .ld_reset(ld_reset), .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
    .ld_x(ld_x), .ld_y(ld_y),
    .px_we(px_we), .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .busy(busy), .lines_done(lines_done)
  );

  // Line drawer stand-in: first pixel the cycle after ld_reset, holds at the end.
  int bx = 0, by = 0, ex = 0, ey = 0, bdx = 0, bdy = 0, bsx = 1, bsy = 1, berr = 0;
  int nx, ny, nerr;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always_comb begin
    nx   = bx;
    ny   = by;
    nerr = berr;
    if (2 * berr >= bdy) begin
      nerr = nerr + bdy;
      nx   = bx + bsx;
    end
    if (2 * berr <= bdx) begin
      nerr = nerr + bdx;
      ny   = by + bsy;
    end
  end

  always @(posedge clk) begin
    if (ld_reset) begin
      bx   <= int'(ld_x0);
      by   <= int'(ld_y0);
      ex   <= int'(ld_x1);
      ey   <= int'(ld_y1);
      bdx  <= iabs(int'(ld_x1) - int'(ld_x0));
      bdy  <= -iabs(int'(ld_y1) - int'(ld_y0));
      bsx  <= (ld_x1 >= ld_x0) ? 1 : -1;
      bsy  <= (ld_y1 >= ld_y0) ? 1 : -1;
      berr <= iabs(int'(ld_x1) - int'(ld_x0)) - iabs(int'(ld_y1) - int'(ld_y0));
    end else if (bx != ex || by != ey) begin
      bx   <= nx;
      by   <= ny;
      berr <= nerr;
    end
  end

  assign ld_x = bx[10:0];
  assign ld_y = by[10:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
    cmd_x0    = 11'(x0);
    cmd_y0    = 11'(y0);
    cmd_x1    = 11'(x1);
    cmd_y1    = 11'(y1);
    cmd_color = 1'(c);
  endtask

  // Counts px_we cycles over a window, recording first and last written pixel.
  task automatic watch(input int cycles, output int n, output int fx, output int fy,
                       output int lx, output int ly);
    n = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (px_we) begin
        if (n == 0) begin
          fx = int'(px_x);
          fy = int'(px_y);
        end
        lx = int'(px_x);
        ly = int'(px_y);
        n++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fx, fy, lx, ly, base, w;
    logic [13:0] pat;
    int nbits;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_px_we", px_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lines", lines_done, 0);
    chk("rst_ld_reset", ld_reset, 0);

    // Horizontal (0,0)->(3,0), colour 1
    set_cmd(0, 0, 3, 0, 1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("h_busy_e0", busy, 1);
    chk("h_we_e0", px_we, 0);
    @(negedge clk);
    chk("h_ld_reset", ld_reset, 1);
    chk("h_ld_x1", ld_x1, 3);
    @(negedge clk);
    chk("h_we_e2", px_we, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("h_we", px_we, 1);
      chk("h_px_x", px_x, i);
      chk("h_px_y", px_y, 0);
      chk("h_color", px_color, 1);
    end
    chk("h_lines", lines_done, 1);
    @(negedge clk);
    chk("h_we_end", px_we, 0);
    chk("h_busy_end", busy, 0);

    // Steep reversed (2,5)->(0,0)
    set_cmd(2, 5, 0, 0, 1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    watch(15, n, fx, fy, lx, ly);
    chk("s_count", n, 6);
    chk("s_first_x", fx, 2);
    chk("s_first_y", fy, 5);
    chk("s_last_x", lx, 0);
    chk("s_last_y", ly, 0);
    chk("s_lines", lines_done, 2);
    chk("s_busy", busy, 0);

    // Back-to-back: N=4, 1, 6
    base = int'(lines_done);
    cmd_valid = 1'b1;
    set_cmd(0, 0, 3, 0, 1);
    @(negedge clk);
    set_cmd(7, 7, 7, 7, 0);
    @(negedge clk);
    set_cmd(2, 5, 0, 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    pat = '0;
    nbits = 0;
    for (int i = 0; i < 40 && nbits < 14; i++) begin
      @(negedge clk);
      if (nbits > 0 || px_we) begin
        pat = {pat[12:0], px_we};
        nbits++;
      end
    end
    chk("b2b_pattern", pat, 14'b11110101111110);
    chk("b2b_lines", lines_done, base + 3);

    // Degenerate (7,7)->(7,7)
    base = int'(lines_done);
    set_cmd(7, 7, 7, 7, 1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    watch(10, n, fx, fy, lx, ly);
    chk("d_count", n, 1);
    chk("d_x", fx, 7);
    chk("d_y", fy, 7);
    chk("d_lines", lines_done, base + 1);

    // FIFO full behind a 2048-pixel line
    base = int'(lines_done);
    for (int i = 0; i < 5; i++) begin
      chk("f_ready_pre", cmd_ready, 1);
      if (i == 0) set_cmd(0, 0, 2047, 0, 1);
      else set_cmd(1, 1, 1, 1, 1);
      cmd_valid = 1'b1;
      @(negedge clk);
    end
    chk("f_full_after5", cmd_ready, 0);
    set_cmd(3, 3, 3, 3, 0);
    w = 0;
    while (!cmd_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("f_sixth_ready", cmd_ready, 1);
    chk("f_sixth_held", (w > 2000), 1);
    chk("f_pop_lines", lines_done, base + 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("f_refull", cmd_ready, 0);
    w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("f_drained", busy, 0);
    chk("f_lines", lines_done, base + 6);

    // Reset in the middle of a 100-pixel line with two queued
    cmd_valid = 1'b1;
    set_cmd(0, 0, 99, 0, 1);
    @(negedge clk);
    set_cmd(4, 4, 4, 4, 1);
    @(negedge clk);
    set_cmd(5, 5, 5, 5, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!(px_we && px_x == 11'd9) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("r_reached_px10", px_x, 9);
    reset = 1'b1;
    @(negedge clk);
    chk("r_px_we", px_we, 0);
    chk("r_px_x", px_x, 0);
    chk("r_px_y", px_y, 0);
    chk("r_color", px_color, 0);
    chk("r_ld_reset", ld_reset, 0);
    chk("r_ld_ends", {ld_x0, ld_y0, ld_x1[9:0]}, 0);
    chk("r_ld_x1", ld_x1, 0);
    chk("r_busy", busy, 0);
    chk("r_lines", lines_done, 0);
    chk("r_ready", cmd_ready, 1);
    reset = 1'b0;
    watch(20, n, fx, fy, lx, ly);
    chk("r_no_writes", n, 0);
    chk("r_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
